// File: rtl/fft_agu_pipe.sv
// Radix-2 in-place FFT address generator: per-butterfly read addresses, ping-pong banks and a
// stall-aware write-back pipeline. Define FFT_AGU_INVERSE_EN to latch 'inverse' and drive tw_conj.
module fft_agu_pipe #(
   parameter int LOG2N    = 9,
   parameter int PIPE_LAT = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       inverse,
   input  logic                       stall,
   output logic [LOG2N-1:0]           rd_addr_a,
   output logic [LOG2N-1:0]           rd_addr_b,
   output logic [LOG2N-2:0]           tw_addr,
   output logic                       rd_valid,
   output logic                       rd_bank,
   output logic [LOG2N-1:0]           wr_addr_a,
   output logic [LOG2N-1:0]           wr_addr_b,
   output logic                       wr_en0,
   output logic                       wr_en1,
   output logic [$clog2(LOG2N+1)-1:0] stage,
   output logic                       busy,
   output logic                       done,
   output logic                       tw_conj
);

   localparam int SW = $clog2(LOG2N+1);
   localparam int JW = LOG2N-1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state, state_nxt;
   logic [JW-1:0]   j, j_nxt;
   logic [SW-1:0]   stage_q, stage_nxt;
   logic            in_run;
   logic            inflight;

   logic [LOG2N-1:0] addr_a_p0, addr_b_p0;
   logic [JW-1:0]    tw_p0;
   logic             vld_p0;

   logic             vld_p    [PIPE_LAT];
   logic [LOG2N-1:0] addr_a_p [PIPE_LAT];
   logic [LOG2N-1:0] addr_b_p [PIPE_LAT];
   logic             bank_p   [PIPE_LAT];

   function automatic logic [LOG2N-1:0] rotl(input logic [LOG2N-1:0] v, input logic [SW-1:0] s);
      return (v << s) | (v >> (SW'(LOG2N) - s));
   endfunction

   // Keep only the j bits above the butterfly span of this stage; stage 0 clears everything.
   function automatic logic [JW-1:0] tw_mask(input logic [JW-1:0] jj, input logic [SW-1:0] s);
      logic [SW-1:0] sh;
      logic [JW-1:0] low;
      sh  = SW'(LOG2N-1) - s;
      low = (JW'(1) << sh) - JW'(1);
      return jj & ~low;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         state   <= IDLE;
         j       <= '0;
         stage_q <= '0;
      end else begin
         state   <= state_nxt;
         j       <= j_nxt;
         stage_q <= stage_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      j_nxt     = j;
      stage_nxt = stage_q;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               j_nxt     = '0;
               stage_nxt = '0;
            end
         end
         RUN: begin
            if (!stall) begin
               j_nxt = j + 1'b1;
               if (j == {JW{1'b1}}) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!stall && !inflight) begin
               if (stage_q == SW'(LOG2N-1)) begin
                  state_nxt = DONE;
               end else begin
                  stage_nxt = stage_q + 1'b1;
                  j_nxt     = '0;
                  state_nxt = RUN;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Issue stage (p0): addresses are a pure function of j and stage.
   assign in_run    = (state == RUN);
   assign vld_p0    = in_run & ~stall;
   assign addr_a_p0 = rotl({j, 1'b0}, stage_q);
   assign addr_b_p0 = rotl({j, 1'b1}, stage_q);
   assign tw_p0     = tw_mask(j, stage_q);

   assign rd_valid  = vld_p0;
   assign rd_addr_a = in_run ? addr_a_p0 : '0;
   assign rd_addr_b = in_run ? addr_b_p0 : '0;
   assign tw_addr   = in_run ? tw_p0 : '0;
   assign rd_bank   = stage_q[0];
   assign stage     = stage_q;
   assign busy      = (state == RUN) | (state == DRAIN);
   assign done      = (state == DONE);

   // Write-back stages p0..p(PIPE_LAT-1): frozen as a whole while stalled.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < PIPE_LAT; i++) begin
            vld_p[i]    <= 1'b0;
            addr_a_p[i] <= '0;
            addr_b_p[i] <= '0;
            bank_p[i]   <= 1'b0;
         end
      end else if (!stall) begin
         vld_p[0]    <= vld_p0;
         addr_a_p[0] <= addr_a_p0;
         addr_b_p[0] <= addr_b_p0;
         bank_p[0]   <= stage_q[0];
         for (int i = 1; i < PIPE_LAT; i++) begin
            vld_p[i]    <= vld_p[i-1];
            addr_a_p[i] <= addr_a_p[i-1];
            addr_b_p[i] <= addr_b_p[i-1];
            bank_p[i]   <= bank_p[i-1];
         end
      end
   end

   // The output slot drains in the same cycle DRAIN exits, so only earlier slots count.
   always_comb begin
      inflight = 1'b0;
      for (int i = 0; i < PIPE_LAT-1; i++) inflight = inflight | vld_p[i];
   end

   assign wr_addr_a = addr_a_p[PIPE_LAT-1];
   assign wr_addr_b = addr_b_p[PIPE_LAT-1];
   assign wr_en0    = vld_p[PIPE_LAT-1] &  bank_p[PIPE_LAT-1] & ~stall;
   assign wr_en1    = vld_p[PIPE_LAT-1] & ~bank_p[PIPE_LAT-1] & ~stall;

`ifdef FFT_AGU_INVERSE_EN
   logic inv_q;

   always_ff @(posedge clk) begin
      if (!reset)                    inv_q <= 1'b0;
      else if (state == IDLE && start) inv_q <= inverse;
   end

   assign tw_conj = inv_q & busy;
`else
   logic unused_inverse;
   assign unused_inverse = inverse;
   assign tw_conj        = 1'b0;
`endif

endmodule

// File: tb/tb_fft_agu_pipe.sv
// Self-checking bench for fft_agu_pipe (LOG2N=3, PIPE_LAT=2) against a transaction-level model.
module tb_fft_agu_pipe;

   localparam int L  = 3;
   localparam int P  = 2;
   localparam int N  = 1 << L;
   localparam int H  = N / 2;
   localparam int M  = H + P;
   localparam int SW = $clog2(L+1);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic          inverse = 1'b0;
   logic          stall = 1'b0;
   logic [L-1:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [L-2:0]  tw_addr;
   logic          rd_valid, rd_bank, wr_en0, wr_en1, busy, done, tw_conj;
   logic [SW-1:0] stage;

   fft_agu_pipe #(.LOG2N(L), .PIPE_LAT(P)) dut (
      .clk(clk), .reset(reset), .start(start), .inverse(inverse), .stall(stall),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
      .rd_valid(rd_valid), .rd_bank(rd_bank), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
      .wr_en0(wr_en0), .wr_en1(wr_en1), .stage(stage), .busy(busy), .done(done),
      .tw_conj(tw_conj)
   );

   always #5 clk = ~clk;

   typedef struct {
      int u;
      int a;
      int b;
      int bank;
   } wr_t;

   int  total = 0;
   int  bad   = 0;
   wr_t wq[$];
   int  phase = 0, n = 0, idle_stage = 0, uc = 0, inv_m = 0, cyc = 0;
   int  last_ev = 0, last_ea = 0, last_eb = 0, last_bank = 0;
   int  busy_cnt = 0, rdv_cnt = 0, wr_cnt = 0, done_cyc = -1;
   bit  cap_en = 1'b0;
   int  cap_a [L][H];
   int  cap_b [L][H];
   int  cap_t [L][H];
   int  cap_bank [L];

   function automatic int rotl(input int x, input int s);
      return ((x << s) | (x >> (L - s))) & (N - 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_cycle();
      int s, pos, ev, ea, eb, et, es, ebusy, edone, econj;
      bit run, exp_w;
      if (phase == 1) begin
         s     = n / M;
         pos   = n % M;
         run   = (pos < H);
         ev    = (run && !stall) ? 1 : 0;
         ea    = run ? rotl(2*pos, s) : 0;
         eb    = run ? rotl(2*pos + 1, s) : 0;
         et    = run ? ((pos & ~((1 << (L-1-s)) - 1)) & (H - 1)) : 0;
         es    = s;
         ebusy = 1;
         edone = 0;
         econj = inv_m;
      end else begin
         ev    = 0; ea = 0; eb = 0; et = 0; pos = 0;
         es    = (phase == 2) ? L - 1 : idle_stage;
         s     = es;
         ebusy = 0;
         edone = (phase == 2) ? 1 : 0;
         econj = 0;
      end
`ifndef FFT_AGU_INVERSE_EN
      econj = 0;
`endif
      chk("rd_valid",  32'(rd_valid),  ev);
      chk("rd_addr_a", 32'(rd_addr_a), ea);
      chk("rd_addr_b", 32'(rd_addr_b), eb);
      chk("tw_addr",   32'(tw_addr),   et);
      chk("stage",     32'(stage),     es);
      chk("rd_bank",   32'(rd_bank),   es & 1);
      chk("busy",      32'(busy),      ebusy);
      chk("done",      32'(done),      edone);
      chk("tw_conj",   32'(tw_conj),   econj);
      if (cap_en && ev == 1) begin
         cap_a[s][pos] = int'(rd_addr_a);
         cap_b[s][pos] = int'(rd_addr_b);
         cap_t[s][pos] = int'(tw_addr);
         cap_bank[s]   = int'(rd_bank);
      end
      exp_w = !stall && wq.size() > 0 && (wq[0].u + P == uc);
      if (exp_w) begin
         chk("wr_en0",    32'(wr_en0),    32'(wq[0].bank == 1));
         chk("wr_en1",    32'(wr_en1),    32'(wq[0].bank == 0));
         chk("wr_addr_a", 32'(wr_addr_a), wq[0].a);
         chk("wr_addr_b", 32'(wr_addr_b), wq[0].b);
         void'(wq.pop_front());
      end else begin
         chk("wr_en0_idle", 32'(wr_en0), 0);
         chk("wr_en1_idle", 32'(wr_en1), 0);
      end
      busy_cnt += int'(busy === 1'b1);
      rdv_cnt  += int'(rd_valid === 1'b1);
      wr_cnt   += int'(wr_en0 === 1'b1) + int'(wr_en1 === 1'b1);
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      last_ev   = ev;
      last_ea   = ea;
      last_eb   = eb;
      last_bank = es & 1;
   endtask

   task automatic model_update();
      if (!stall) begin
         if (last_ev == 1) wq.push_back('{uc, last_ea, last_eb, last_bank});
         uc++;
      end
      case (phase)
         0: if (start) begin
               phase = 1;
               n     = 0;
               inv_m = int'(inverse);
            end
         1: if (!stall) begin
               n++;
               if (n == L * M) phase = 2;
            end
         default: begin
               phase      = 0;
               idle_stage = L - 1;
            end
      endcase
   endtask

   task automatic step(input bit st, input bit inv, input bit stl);
      start   = st;
      inverse = inv;
      stall   = stl;
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      stall = 1'b0;
      @(posedge clk);
      cyc++;
      #1;
      reset      = 1'b1;
      phase      = 0;
      n          = 0;
      idle_stage = 0;
      inv_m      = 0;
      wq.delete();
      chk("rst_rd_valid",  32'(rd_valid),  0);
      chk("rst_rd_addr_a", 32'(rd_addr_a), 0);
      chk("rst_rd_addr_b", 32'(rd_addr_b), 0);
      chk("rst_tw_addr",   32'(tw_addr),   0);
      chk("rst_wr_addr_a", 32'(wr_addr_a), 0);
      chk("rst_wr_addr_b", 32'(wr_addr_b), 0);
      chk("rst_wr_en",     32'({wr_en0, wr_en1}), 0);
      chk("rst_stage",     32'(stage),     0);
      chk("rst_flags",     32'({busy, done, rd_bank, tw_conj}), 0);
   endtask

   // mode 0: no stall, 1: random stall plus ignored start pulses, 2: 3-cycle RUN + 2-cycle DRAIN stall
   task automatic run_fft(input int mode, input bit inv, output int dur);
      int start_cyc, lim, sc, dc;
      bit stl, st;
      busy_cnt  = 0;
      rdv_cnt   = 0;
      wr_cnt    = 0;
      done_cyc  = -1;
      sc        = 0;
      dc        = 0;
      start_cyc = cyc;
      stl       = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      step(1'b1, inv, stl);
      lim = 0;
      while (phase != 0 && lim < 400) begin
         st  = 1'b0;
         stl = 1'b0;
         if (mode == 1) begin
            stl = ($urandom_range(0, 3) == 0);
            st  = ($urandom_range(0, 15) == 0);
         end else if (mode == 2) begin
            if (phase == 1 && n == 2 && sc < 3) begin
               stl = 1'b1;
               sc++;
            end else if (phase == 1 && n == M + H && dc < 2) begin
               stl = 1'b1;
               dc++;
            end
         end
         step(st, 1'($urandom_range(0, 1)), stl);
         lim++;
      end
      chk("done_seen", 32'(done_cyc >= 0), 1);
      chk("write_count", wr_cnt, L * H);
      chk("read_count", rdv_cnt, L * H);
      chk("pending_writes", wq.size(), 0);
      dur = done_cyc - start_cyc;
   endtask

   initial begin
      int dur, lim;
      repeat (2) @(posedge clk);
      do_reset();
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1);

      cap_en = 1'b1;
      run_fft(0, 1'b0, dur);
      cap_en = 1'b0;
      chk("done_latency", dur, 19);
      chk("busy_cycles", busy_cnt, 18);
      chk("s0j2_a", cap_a[0][2], 4);
      chk("s0j2_b", cap_b[0][2], 5);
      chk("s0j2_tw", cap_t[0][2], 0);
      chk("s1j1_a", cap_a[1][1], 4);
      chk("s1j1_b", cap_b[1][1], 6);
      chk("s1j1_tw", cap_t[1][1], 0);
      chk("s2j3_a", cap_a[2][3], 3);
      chk("s2j3_b", cap_b[2][3], 7);
      chk("s2j3_tw", cap_t[2][3], 3);
      chk("bank_s0", cap_bank[0], 0);
      chk("bank_s1", cap_bank[1], 1);
      chk("bank_s2", cap_bank[2], 0);

      step(1'b0, 1'b0, 1'b1);
      run_fft(2, 1'b0, dur);
      chk("stalled_latency", dur, 24);

      step(1'b0, 1'b0, 1'b0);
      run_fft(0, 1'b1, dur);
      chk("inverse_latency", dur, 19);
      step(1'b0, 1'b0, 1'b0);

      for (int r = 0; r < 4; r++) begin
         run_fft(1, 1'($urandom_range(0, 1)), dur);
         step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
      end

      step(1'b1, 1'b1, 1'b0);
      lim = 0;
      while (!(phase == 1 && n == M + 2) && lim < 200) begin
         step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
         lim++;
      end
      chk("reached_stage1", 32'(phase == 1 && n == M + 2), 1);
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
      run_fft(0, 1'b0, dur);
      chk("post_reset_latency", dur, 19);
      step(1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft_agu_pipe.md
Name: fft_agu_pipe

Overview:
Parametrised radix-2 in-place FFT address generation unit with start/done handshake, stall support and write-back pipeline alignment.
- Issues read addresses (A, B, twiddle) per butterfly.
- Delays the same addresses by the butterfly datapath latency to produce write-back addresses and bank write enables.
- Ping-pongs between RAM0 and RAM1 each stage.
- Sits between the FFT top-level controller and the dual data RAMs / twiddle ROM.

Parameters:
- LOG2N, 9: log2 of FFT size N; address width; number of stages (>=2).
- PIPE_LAT, 4: butterfly datapath latency in cycles from read issue to write-back (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins transform when idle
- inverse  in  1  inverse-FFT request, sampled with start
- stall  in  1  freezes issue and write pipeline while high
- rd_addr_a  out  LOG2N  butterfly A read address
- rd_addr_b  out  LOG2N  butterfly B read address
- tw_addr  out  LOG2N-1  twiddle ROM address
- rd_valid  out  1  read addresses valid this cycle
- rd_bank  out  1  bank being read (0=RAM0, 1=RAM1)
- wr_addr_a  out  LOG2N  write-back A address
- wr_addr_b  out  LOG2N  write-back B address
- wr_en0  out  1  write enable RAM0
- wr_en1  out  1  write enable RAM1
- stage  out  $clog2(LOG2N+1)  current stage index
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- tw_conj  out  1  conjugate twiddle (inverse mode)

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; j=0; stage=0; write pipeline cleared. All outputs 0. Applies mid-transform; pending writes are discarded.
- States:
  - IDLE: start=1 -> RUN with stage=0, j=0, busy=1. start is ignored in every other state.
  - RUN: each cycle with stall=0, rd_valid=1 and j increments. When j==N/2-1 issues -> DRAIN.
  - DRAIN: waits until the write pipeline holds no valid entries. Then, if stage<LOG2N-1: stage++, j=0 -> RUN; else -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- rd_valid=0 whenever stall=1 or state!=RUN; j does not advance.
- Address generation (combinational from j and stage):
  - rd_addr_a = rotl_LOG2N(2j, stage)
  - rd_addr_b = rotl_LOG2N(2j+1, stage)
  - tw_addr = j & ~((1<<(LOG2N-1-stage))-1), truncated to LOG2N-1 bits; stage 0 always gives 0.
- rd_bank = stage[0]. Each write targets the opposite bank.
- Write pipeline:
  - PIPE_LAT-deep shift register of {valid, addr_a, addr_b, bank}.
  - Shifts only when stall=0; fully frozen when stall=1, in RUN and DRAIN alike.
  - The entry issued in cycle t emerges in cycle t+PIPE_LAT (no stalls).
  - wr_en0 = out.valid & out.bank==1 & ~stall; wr_en1 = out.valid & out.bank==0 & ~stall.
  - wr_addr_* come from the pipeline output.
- Timing with no stall:
  - start sampled at edge k; first rd_valid in cycle k+1.
  - Each stage takes N/2 + PIPE_LAT cycles.
  - done is high in cycle k+1+LOG2N*(N/2+PIPE_LAT).
- Result resides in RAM(LOG2N mod 2): RAM1 for LOG2N odd.
- Stall asserted in DONE or IDLE has no effect.

Optional Feature:
- Macro: FFT_AGU_INVERSE_EN.
- Defined: inverse is latched at start acceptance. tw_conj equals the latched value while busy, and is 0 in IDLE and after reset.
- Undefined: inverse is ignored; tw_conj is tied to 0.

Test Plan:
- LOG2N=3, PIPE_LAT=2: reset, pulse start at edge 0 -> rd_valid cycles 1-4; done pulse exactly at cycle 19; busy high cycles 1-18.
- LOG2N=3, read addresses:
  - stage0 j=2 -> a=4, b=5, tw=0
  - stage1 j=1 -> a=4, b=6, tw=0
  - stage2 j=3 -> a=3, b=7, tw=3
  - rd_bank = 0, 1, 0 for stages 0, 1, 2.
- Write alignment: every (rd_addr_a, rd_addr_b) issued reappears on wr_addr_* exactly PIPE_LAT unstalled cycles later, with wr_en1 in stage 0 and wr_en0 in stage 1. Exactly 12 write strobes total for LOG2N=3.
- Stall: assert stall 3 cycles mid-RUN and 2 cycles in DRAIN -> no address change, no writes, no lost or duplicated writes. done is delayed by exactly 5 cycles.
- Reset mid-stage-1, then start again -> all outputs 0 after reset; next run restarts at stage 0, j=0; no stale writes emerge. A start pulse while busy is ignored.
- FFT_AGU_INVERSE_EN defined: start with inverse=1 -> tw_conj=1 while busy, 0 after done. With the macro undefined, tw_conj stays 0.
